mx_conv_sched: RTL and testbench

- Shares one bf16-to-MX-int block converter between R requesters. Each requester presents a full k-element bf16 block.
- Round-robin arbitration picks one requester per cycle. The requester ID is carried alongside the converter's fixed-latency pipeline.
- Results are collected in an output FIFO with valid/ready.
- Credit-based issue guarantees the non-stallable converter pipeline never overflows the FIFO.

---
 rtl/mx_conv_sched_if.sv | 31 +++
 rtl/mx_conv_sched.sv | 195 +++++++++++++++++++
 tb/tb_mx_conv_sched.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mx_conv_sched_if.sv
// Requester and result-side bus of the shared MX block converter scheduler.
// Latency: none, this is a bundle of wires.
// Backpressure: requesters see one-hot ready; the consumer throttles with i_out_ready.
interface mx_conv_sched_if #(
    parameter int R  = 4,
    parameter int K  = 32,
    parameter int BW = 8
);
    localparam int ID_W = (R > 1) ? $clog2(R) : 1;

    logic [R-1:0]              i_req_valid;
    logic [R-1:0]              o_req_ready;
    logic [R-1:0][K-1:0][15:0] i_req_vec;
    logic                      o_out_valid;
    logic                      i_out_ready;
    logic [K-1:0][BW-1:0]      o_out_vec;
    logic [7:0]                o_out_exp;
    logic [ID_W-1:0]           o_out_id;

    // Requesters plus result consumer
    modport master (
        output i_req_valid, i_req_vec, i_out_ready,
        input  o_req_ready, o_out_valid, o_out_vec, o_out_exp, o_out_id
    );

    // Scheduler side
    modport slave (
        input  i_req_valid, i_req_vec, i_out_ready,
        output o_req_ready, o_out_valid, o_out_vec, o_out_exp, o_out_id
    );
endinterface

// File: rtl/mx_conv_sched.sv
// Round-robin share of one bf16->MX converter across R requesters; IDs ride a tag pipe to an FWFT result FIFO.
// Latency: block accepted in cycle t is at the FIFO head in cycle t+CONV_LAT+1 when the FIFO was empty.
// Backpressure: credits cover in-flight tags plus FIFO entries, no grant at FIFO_DEPTH. Macro MX_SCHED_STATS_EN adds counters.
module mx_conv_sched #(
    parameter int R          = 4,
    parameter int K          = 32,
    parameter int BIT_WIDTH  = 8,
    parameter int CONV_LAT   = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    mx_conv_sched_if.slave                bus,
    output logic [K-1:0][15:0]            o_conv_vec,
    input  logic [K-1:0][BIT_WIDTH-1:0]   i_conv_mx_vec,
    input  logic [7:0]                    i_conv_mx_exp,
    output logic                          o_busy,
    output logic [31:0]                   o_stat_issued,
    output logic [31:0]                   o_stat_stall
);
    localparam int ID_W  = (R > 1) ? $clog2(R) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LAST  = CONV_LAT - 1;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [K-1:0][BIT_WIDTH-1:0] vec;
        logic [7:0]                  exp;
        logic [ID_W-1:0]             id;
    } entry_t;

    logic [ID_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0] reserved_q, reserved_d;
    tag_t             tag_q [CONV_LAT];
    tag_t             tag_d [CONV_LAT];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    entry_t           mem_q [FIFO_DEPTH];
    entry_t           wr_entry;
    entry_t           head;

    logic             issue_ok;
    logic             grant_any;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;
    logic [R-1:0]     grant_oh;
    logic             fifo_wr;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit check, round-robin search from the pointer, and converter input mux
    always_comb begin
        // Requesters must never see ready while reset is applied: the block would be dropped.
        issue_ok  = i_rst_n && (reserved_q < CNT_W'(FIFO_DEPTH));
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        cand      = '0;
        if (issue_ok) begin
            for (int i = 1; i <= R; i++) begin
                cand = ID_W'((int'(rr_q) + i) % R);
                if (!grant_any && bus.i_req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
        rr_d       = grant_any ? grant_idx : rr_q;
        o_conv_vec = grant_any ? bus.i_req_vec[grant_idx] : '0;
    end

    // Reserved credits: +1 on issue, -1 on pop, unchanged on both
    always_comb begin
        reserved_d = reserved_q;
        case ({grant_any, fifo_pop})
            2'b10:   reserved_d = reserved_q + 1'b1;
            2'b01:   reserved_d = reserved_q - 1'b1;
            default: reserved_d = reserved_q;
        endcase
    end

    // Tag pipeline mirrors the converter latency so IDs line up with results
    always_comb begin
        tag_d[0].vld = grant_any;
        tag_d[0].id  = grant_idx;
        for (int i = 1; i < CONV_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // FIFO pointer/count update; write and pop may both happen in one cycle
    always_comb begin
        fifo_empty   = (cnt_q == '0);
        fifo_full    = (cnt_q == CNT_W'(FIFO_DEPTH));
        fifo_wr      = tag_q[LAST].vld;
        fifo_pop     = !fifo_empty && bus.i_out_ready;
        wr_entry.vec = i_conv_mx_vec;
        wr_entry.exp = i_conv_mx_exp;
        wr_entry.id  = tag_q[LAST].id;
        wr_ptr_d     = fifo_wr  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = fifo_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d        = cnt_q;
        case ({fifo_wr, fifo_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        head = mem_q[rd_ptr_q];
    end

    // Control state; reset drops every in-flight tag and empties the FIFO
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_q       <= ID_W'(R - 1);
            reserved_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < CONV_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            rr_q       <= rr_d;
            reserved_q <= reserved_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            for (int i = 0; i < CONV_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // FIFO storage needs no reset; the count gates what is visible
    always_ff @(posedge i_clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign bus.o_req_ready = grant_oh;
    assign bus.o_out_valid = !fifo_empty;
    assign bus.o_out_vec   = fifo_empty ? '0 : head.vec;
    assign bus.o_out_exp   = fifo_empty ? '0 : head.exp;
    assign bus.o_out_id    = fifo_empty ? '0 : head.id;
    assign o_busy          = (reserved_q != '0);

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(fifo_wr && fifo_full && !fifo_pop));
`endif

`ifdef MX_SCHED_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Grant count and cycles where someone waits on exhausted credits
    always_comb begin
        stat_issued_d = stat_issued_q + {31'd0, grant_any};
        stat_stall_d  = stat_stall_q +
                        {31'd0, (|bus.i_req_valid) && (reserved_q == CNT_W'(FIFO_DEPTH))};
    end

    // Statistics registers, free-running wrap
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign o_stat_issued = stat_issued_q;
    assign o_stat_stall  = stat_stall_q;
`else
    assign o_stat_issued = '0;
    assign o_stat_stall  = '0;
`endif
endmodule

// File: tb/tb_mx_conv_sched.sv
// Directed bench for mx_conv_sched with a behavioural fixed-latency converter.
// Latency: converter model is CONV_LAT registered stages.
// Backpressure: consumer ready is driven per scenario.
module tb_mx_conv_sched;
    localparam int R     = 4;
    localparam int K     = 32;
    localparam int BW    = 8;
    localparam int LAT   = 5;
    localparam int DEPTH = 8;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n = 1'b0;
    logic [K-1:0][15:0]   conv_vec;
    logic [K-1:0][BW-1:0] conv_mx_vec;
    logic [7:0]           conv_mx_exp;
    logic                 busy;
    logic [31:0]          stat_issued;
    logic [31:0]          stat_stall;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gq[$];
    int pq_id[$];
    int pq_exp[$];
    int pq_cyc[$];

    mx_conv_sched_if #(.R(R), .K(K), .BW(BW)) bus ();

    mx_conv_sched #(
        .R(R), .K(K), .BIT_WIDTH(BW), .CONV_LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .bus           (bus),
        .o_conv_vec    (conv_vec),
        .i_conv_mx_vec (conv_mx_vec),
        .i_conv_mx_exp (conv_mx_exp),
        .o_busy        (busy),
        .o_stat_issued (stat_issued),
        .o_stat_stall  (stat_stall)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Simple converter: shared exp = max biased exponent, element = signed aligned mantissa
    function automatic logic [7:0] conv_exp(input logic [K-1:0][15:0] v);
        logic [7:0] m;
        m = 8'd0;
        for (int i = 0; i < K; i++) if (v[i][14:7] > m) m = v[i][14:7];
        return m;
    endfunction

    function automatic logic [K-1:0][BW-1:0] conv_elems(input logic [K-1:0][15:0] v);
        logic [K-1:0][BW-1:0] r;
        logic [7:0] m;
        logic [7:0] e;
        logic [7:0] mag;
        int sh;
        m = conv_exp(v);
        r = '0;
        for (int i = 0; i < K; i++) begin
            e = v[i][14:7];
            if (e != 8'd0) begin
                sh  = int'(m) - int'(e) + 1;
                mag = (sh > 7) ? 8'd0 : ({1'b1, v[i][6:0]} >> sh);
                r[i] = v[i][15] ? -mag : mag;
            end
        end
        return r;
    endfunction

    logic [K-1:0][BW-1:0] cv_q [LAT];
    logic [7:0]           ce_q [LAT];

    always @(posedge i_clk) begin
        cv_q[0] <= conv_elems(conv_vec);
        ce_q[0] <= conv_exp(conv_vec);
        for (int i = 1; i < LAT; i++) begin
            cv_q[i] <= cv_q[i-1];
            ce_q[i] <= ce_q[i-1];
        end
    end

    assign conv_mx_vec = cv_q[LAT-1];
    assign conv_mx_exp = ce_q[LAT-1];

    // Record grants and pops mid-cycle
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            for (int i = 0; i < R; i++) if (bus.o_req_ready[i]) gq.push_back(i);
            if (bus.o_out_valid && bus.i_out_ready) begin
                pq_id.push_back(int'(bus.o_out_id));
                pq_exp.push_back(int'(bus.o_out_exp));
                pq_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_q();
        gq.delete();
        pq_id.delete();
        pq_exp.delete();
        pq_cyc.delete();
    endtask

    task automatic do_reset();
        bus.i_req_valid = '0;
        bus.i_out_ready = 1'b0;
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        clear_q();
    endtask

    // Requester r presents 2^r in every element: exp 127+r, elements 0x40
    task automatic set_vecs();
        for (int r = 0; r < R; r++)
            for (int e = 0; e < K; e++)
                bus.i_req_vec[r][e] = 16'h3F80 + 16'(r << 7);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.o_out_valid); end
        checks++; if (bus.o_out_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", bus.o_out_id); end
        checks++; if (bus.o_out_exp !== 8'd0) begin errors++; $display("FAIL reset_exp: got %0h want 0", bus.o_out_exp); end
        checks++; if (bus.o_out_vec !== '0) begin errors++; $display("FAIL reset_vec: got nonzero want 0"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (stat_issued !== 32'd0 || stat_stall !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_issued, stat_stall); end
        bus.i_req_valid = 4'hF;
        #1;
        checks++; if (bus.o_req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_prio: got %b want 0001", bus.o_req_ready); end
        bus.i_req_valid = 4'h0;
    endtask

    task automatic test_single();
        int lat;
        do_reset();
        set_vecs();
        for (int e = 0; e < K; e++) bus.i_req_vec[2][e] = 16'h3F80;
        repeat (3) step();
        bus.i_req_valid = 4'b0100;
        #1;
        checks++; if (bus.o_req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", bus.o_req_ready); end
        checks++; if (conv_vec[0] !== 16'h3F80) begin errors++; $display("FAIL single_conv_vec: got %h want 3f80", conv_vec[0]); end
        step();
        bus.i_req_valid = 4'b0000;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b want 1", busy); end
        lat = 1;
        while (!bus.o_out_valid && lat < 20) begin step(); lat++; end
        checks++; if (lat !== 6) begin errors++; $display("FAIL single_latency: got %0d want 6", lat); end
        checks++; if (bus.o_out_id !== 2'd2) begin errors++; $display("FAIL single_id: got %0d want 2", bus.o_out_id); end
        checks++; if (bus.o_out_exp !== 8'd127) begin errors++; $display("FAIL single_exp: got %0d want 127", bus.o_out_exp); end
        checks++; if (bus.o_out_vec[0] !== 8'h40 || bus.o_out_vec[K-1] !== 8'h40) begin errors++; $display("FAIL single_elem: got %h/%h want 40/40", bus.o_out_vec[0], bus.o_out_vec[K-1]); end
        repeat (2) step();
        checks++; if (bus.o_out_valid !== 1'b1 || bus.o_out_id !== 2'd2 || bus.o_out_exp !== 8'd127) begin errors++; $display("FAIL single_hold: got v=%0b id=%0d exp=%0d want 1/2/127", bus.o_out_valid, bus.o_out_id, bus.o_out_exp); end
        bus.i_out_ready = 1'b1;
        step();
        checks++; if (bus.o_out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drain: got v=%0b busy=%0b want 0/0", bus.o_out_valid, busy); end
    endtask

    task automatic test_round_robin();
        int ord [3] = '{0, 1, 3};
        do_reset();
        set_vecs();
        bus.i_out_ready = 1'b1;
        bus.i_req_valid = 4'b1011;
        repeat (12) step();
        bus.i_req_valid = 4'b0000;
        repeat (12) step();
        checks++; if (gq.size() !== 12) begin errors++; $display("FAIL rr_grants: got %0d want 12", gq.size()); end
        checks++; if (pq_id.size() !== 12) begin errors++; $display("FAIL rr_pops: got %0d want 12", pq_id.size()); end
        for (int j = 0; j < 12 && j < gq.size() && j < pq_id.size(); j++) begin
            checks++; if (gq[j] !== ord[j % 3]) begin errors++; $display("FAIL rr_grant_order[%0d]: got %0d want %0d", j, gq[j], ord[j % 3]); end
            checks++; if (pq_id[j] !== ord[j % 3] || pq_exp[j] !== 127 + ord[j % 3]) begin errors++; $display("FAIL rr_out[%0d]: got id=%0d exp=%0d want id=%0d exp=%0d", j, pq_id[j], pq_exp[j], ord[j % 3], 127 + ord[j % 3]); end
        end
        if (pq_cyc.size() == 12) begin
            checks++; if (pq_cyc[11] - pq_cyc[0] !== 11) begin errors++; $display("FAIL rr_no_bubbles: got span %0d want 11", pq_cyc[11] - pq_cyc[0]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_vecs();
        bus.i_req_valid = 4'hF;
        repeat (20) step();
        checks++; if (gq.size() !== 8) begin errors++; $display("FAIL bp_grants: got %0d want 8", gq.size()); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %0b want 1", busy); end
        bus.i_out_ready = 1'b1;
        #1;
        checks++; if (bus.o_req_ready !== 4'b0000) begin errors++; $display("FAIL bp_pop_no_issue: got %b want 0000", bus.o_req_ready); end
        step();
        bus.i_out_ready = 1'b0;
        #1;
        checks++; if (bus.o_req_ready !== 4'b0001) begin errors++; $display("FAIL bp_one_credit: got %b want 0001", bus.o_req_ready); end
        repeat (6) step();
        checks++; if (gq.size() !== 9) begin errors++; $display("FAIL bp_total_grants: got %0d want 9", gq.size()); end
        checks++; if (pq_id.size() !== 1) begin errors++; $display("FAIL bp_one_pop: got %0d want 1", pq_id.size()); end
        bus.i_req_valid = 4'h0;
        bus.i_out_ready = 1'b1;
        repeat (20) step();
        checks++; if (pq_id.size() !== 9) begin errors++; $display("FAIL bp_drain: got %0d want 9", pq_id.size()); end
    endtask

    task automatic test_issue_pop_wrap();
        int issued;
        do_reset();
        set_vecs();
        bus.i_req_valid = 4'b0001;
        repeat (7) step();
        bus.i_req_valid = 4'b0000;
        repeat (8) step();
        bus.i_req_valid = 4'b0001;
        bus.i_out_ready = 1'b1;
        #1;
        checks++; if (bus.o_req_ready !== 4'b0001) begin errors++; $display("FAIL ip_issue_at_7: got %b want 0001", bus.o_req_ready); end
        step();
        bus.i_out_ready = 1'b0;
        #1;
        checks++; if (bus.o_req_ready !== 4'b0001) begin errors++; $display("FAIL ip_reserved_held: got %b want 0001", bus.o_req_ready); end
        step();
        checks++; if (bus.o_req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL ip_full: got ready=%b busy=%0b want 0000/1", bus.o_req_ready, busy); end
        bus.i_req_valid = 4'b0000;
        bus.i_out_ready = 1'b1;
        repeat (20) step();
        checks++; if (pq_id.size() !== 9) begin errors++; $display("FAIL ip_pops: got %0d want 9", pq_id.size()); end

        do_reset();
        issued = 0;
        for (int c = 0; c < 600 && pq_id.size() < 24; c++) begin
            bus.i_req_valid = (issued < 24) ? 4'hF : 4'h0;
            bus.i_out_ready = ((c % 5) < 2);
            #1;
            if (bus.o_req_ready != 4'b0000) issued++;
            step();
        end
        bus.i_req_valid = 4'h0;
        checks++; if (issued !== 24) begin errors++; $display("FAIL wrap_issued: got %0d want 24", issued); end
        checks++; if (pq_id.size() !== 24) begin errors++; $display("FAIL wrap_pops: got %0d want 24", pq_id.size()); end
        for (int j = 0; j < pq_id.size(); j++) begin
            checks++; if (pq_id[j] !== j % 4 || pq_exp[j] !== 127 + j % 4) begin errors++; $display("FAIL wrap_order[%0d]: got id=%0d exp=%0d want id=%0d exp=%0d", j, pq_id[j], pq_exp[j], j % 4, 127 + j % 4); end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int stale;
        do_reset();
        set_vecs();
        bus.i_req_valid = 4'hF;
        repeat (2) step();
        bus.i_req_valid = 4'h0;
        repeat (3) step();
        bus.i_req_valid = 4'hF;
        repeat (3) step();
        bus.i_req_valid = 4'h0;
        checks++; if (bus.o_out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rm_pre: got v=%0b busy=%0b want 1/1", bus.o_out_valid, busy); end
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        clear_q();
        checks++; if (bus.o_out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_flushed: got v=%0b busy=%0b want 0/0", bus.o_out_valid, busy); end
        bus.i_out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < LAT + 2; c++) begin
            if (bus.o_out_valid) stale++;
            step();
        end
        checks++; if (stale !== 0) begin errors++; $display("FAIL rm_stale: got %0d valid cycles want 0", stale); end
        bus.i_req_valid = 4'hF;
        #1;
        checks++; if (bus.o_req_ready !== 4'b0001) begin errors++; $display("FAIL rm_first_grant: got %b want 0001", bus.o_req_ready); end
        step();
        bus.i_req_valid = 4'h0;
        lat = 1;
        while (!bus.o_out_valid && lat < 20) begin step(); lat++; end
        checks++; if (lat !== 6 || bus.o_out_id !== 2'd0) begin errors++; $display("FAIL rm_new_out: got lat=%0d id=%0d want 6/0", lat, bus.o_out_id); end
        repeat (3) step();
        checks++; if (pq_id.size() !== 1) begin errors++; $display("FAIL rm_count: got %0d want 1", pq_id.size()); end
    endtask

    task automatic test_stats();
        logic [31:0] want_issued;
        logic [31:0] want_stall;
`ifdef MX_SCHED_STATS_EN
        want_issued = 32'd20;
        want_stall  = 32'd7;
`else
        want_issued = 32'd0;
        want_stall  = 32'd0;
`endif
        do_reset();
        set_vecs();
        bus.i_req_valid = 4'hF;
        repeat (15) step();
        bus.i_req_valid = 4'h0;
        bus.i_out_ready = 1'b1;
        repeat (15) step();
        bus.i_req_valid = 4'b0001;
        repeat (12) step();
        bus.i_req_valid = 4'h0;
        repeat (15) step();
        checks++; if (gq.size() !== 20) begin errors++; $display("FAIL stats_grants: got %0d want 20", gq.size()); end
        checks++; if (stat_issued !== want_issued) begin errors++; $display("FAIL stats_issued: got %0d want %0d", stat_issued, want_issued); end
        checks++; if (stat_stall !== want_stall) begin errors++; $display("FAIL stats_stall: got %0d want %0d", stat_stall, want_stall); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        bus.i_req_valid = '0;
        bus.i_out_ready = 1'b0;
        bus.i_req_vec   = '0;
        repeat (2) @(posedge i_clk);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_issue_pop_wrap();
        test_reset_mid();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
